// File: rtl/etu_rate_scheduler_if.sv
// Rate-change handshake between the PPS/ATR requester and the ETU scheduler,
// plus the line-status inputs and ETU outputs consumed by the bit engine.
interface etu_rate_scheduler_if;
    logic        cfgReq;
    logic [3:0]  fiCode;
    logic [3:0]  diCode;
    logic        cfgReady;
    logic        cfgAck;
    logic        cfgErr;
    logic        lineIdle;
    logic        etuResync;
    logic [12:0] cyclesPerEtu;
    logic        etuTick;

    modport master (
        output cfgReq, fiCode, diCode, lineIdle, etuResync,
        input  cfgReady, cfgAck, cfgErr, cyclesPerEtu, etuTick
    );

    modport slave (
        input  cfgReq, fiCode, diCode, lineIdle, etuResync,
        output cfgReady, cfgAck, cfgErr, cyclesPerEtu, etuTick
    );
endinterface

// File: rtl/etu_rate_scheduler.sv
// ETU bit-clock owner: decodes (FI,DI), divides Fi/Di serially, waits for a
// quiet line and then switches cycles-per-ETU in a single cycle.
//
// state     | meaning
// IDLE      | ready for a request, old rate ticking
// LOOKUP    | decode latched codes, reject RFU or seed the divider
// DIVIDE    | 12 restoring shift-subtract steps producing floor(Fi/Di)
// WAIT_IDLE | count consecutive idle ETUs until the guard is met
// APPLY     | load new rate, restart the ETU counter, acknowledge
module etu_rate_scheduler #(
    parameter int unsigned DEFAULT_CYCLES = 372,
    parameter int unsigned GUARD_ETU      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    etu_rate_scheduler_if.slave  bus
);
    localparam int IW = $clog2(GUARD_ETU + 2);
    localparam logic [IW:0] GUARD_X = (IW + 1)'(GUARD_ETU);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        DIVIDE    = 3'd2,
        WAIT_IDLE = 3'd3,
        APPLY     = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  fi_lat;
    logic [3:0]  di_lat;
    logic [11:0] fi_val;
    logic [6:0]  di_val;
    logic        fi_rfu;
    logic        di_rfu;
    logic        code_rfu;

    logic [11:0] dq;
    logic [6:0]  rem;
    logic [6:0]  divisor;
    logic [3:0]  div_cnt;
    logic [7:0]  trial;
    logic [6:0]  diff;
    logic        q_bit;

    logic [12:0] count;
    logic [12:0] cpe;
    logic        last_cycle;
    logic        tick;

    logic [IW-1:0] idle_cnt;
    logic [IW:0]   idle_inc;
    logic          guard_met;

    always_comb begin
        fi_val = 12'd0;
        fi_rfu = 1'b0;
        case (fi_lat)
            4'h0, 4'h1: fi_val = 12'd372;
            4'h2:       fi_val = 12'd558;
            4'h3:       fi_val = 12'd744;
            4'h4:       fi_val = 12'd1116;
            4'h5:       fi_val = 12'd1488;
            4'h6:       fi_val = 12'd1860;
            4'h9:       fi_val = 12'd512;
            4'hA:       fi_val = 12'd768;
            4'hB:       fi_val = 12'd1024;
            4'hC:       fi_val = 12'd1536;
            4'hD:       fi_val = 12'd2048;
            default:    fi_rfu = 1'b1;
        endcase
    end

    always_comb begin
        di_val = 7'd0;
        di_rfu = 1'b0;
        case (di_lat)
            4'h1:    di_val = 7'd1;
            4'h2:    di_val = 7'd2;
            4'h3:    di_val = 7'd4;
            4'h4:    di_val = 7'd8;
            4'h5:    di_val = 7'd16;
            4'h6:    di_val = 7'd32;
            4'h7:    di_val = 7'd64;
            4'h8:    di_val = 7'd12;
            4'h9:    di_val = 7'd20;
            default: di_rfu = 1'b1;
        endcase
    end

    assign code_rfu = fi_rfu | di_rfu;

    // Partial remainder always stays below the divisor (<= 64), so 7 bits hold
    // it and the low 7 bits of the subtraction are exact whenever it is taken.
    assign trial = {rem, dq[11]};
    assign q_bit = (trial >= {1'b0, divisor});
    assign diff  = trial[6:0] - divisor;

    assign last_cycle = (count == cpe - 13'd1);
    assign tick       = last_cycle && !bus.etuResync && (state != APPLY);

    assign idle_inc  = {1'b0, idle_cnt} + 1'b1;
    assign guard_met = ({1'b0, idle_cnt} == GUARD_X) ||
                       (bus.lineIdle && tick && (idle_inc == GUARD_X));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.cfgReq) state_next = LOOKUP;
            LOOKUP:    state_next = code_rfu ? IDLE : DIVIDE;
            DIVIDE:    if (div_cnt == 4'd0) state_next = WAIT_IDLE;
            WAIT_IDLE: if (guard_met) state_next = APPLY;
            APPLY:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cfgReady     = (state == IDLE);
        bus.cfgAck       = (state == APPLY);
        bus.cfgErr       = (state == LOOKUP) && code_rfu;
        bus.etuTick      = tick;
        bus.cyclesPerEtu = cpe;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fi_lat <= 4'd0;
            di_lat <= 4'd0;
        end else if (state == IDLE && bus.cfgReq) begin
            fi_lat <= bus.fiCode;
            di_lat <= bus.diCode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dq      <= 12'd0;
            rem     <= 7'd0;
            divisor <= 7'd0;
            div_cnt <= 4'd0;
        end else if (state == LOOKUP) begin
            dq      <= fi_val;
            rem     <= 7'd0;
            divisor <= di_val;
            div_cnt <= 4'd11;
        end else if (state == DIVIDE) begin
            rem     <= q_bit ? diff : trial[6:0];
            dq      <= {dq[10:0], q_bit};
            div_cnt <= div_cnt - 4'd1;
        end
    end

    // A change of rate restarts the ETU from zero so the first new ETU is full length.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 13'd0;
            cpe   <= 13'(DEFAULT_CYCLES);
        end else if (state == APPLY) begin
            count <= 13'd0;
            cpe   <= {1'b0, dq};
        end else if (bus.etuResync || last_cycle) begin
            count <= 13'd0;
        end else begin
            count <= count + 13'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != WAIT_IDLE || !bus.lineIdle) begin
            idle_cnt <= '0;
        end else if (tick) begin
            idle_cnt <= idle_inc[IW-1:0];
        end
    end
endmodule
